// File: rtl/rram_op_sequencer_if.sv
// Wishbone classic slave bus bundle for the RRAM operation sequencer.
// Signal names keep the Wishbone-side direction affixes seen from the slave.
interface rram_op_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/rram_op_sequencer.sv
// Wishbone-controlled RRAM READ/SET/RESET/MAC phase sequencer with registered strobes.
// Optional write-verify retry loop is enabled by defining RRAM_SEQ_VERIFY_EN.
module rram_op_sequencer #(
    parameter int unsigned ADC_W   = 3,
    parameter int unsigned PRE_CYC = 4,
    parameter int unsigned ADC_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rram_op_sequencer_if.slave  wb,
    output logic [1:0]          wl_sel,
    output logic [1:0]          bl_sel,
    output logic [1:0]          sl_sel,
    output logic                wl_en,
    output logic                pre_en,
    output logic                csa_en,
    output logic                adc_smp,
    input  logic [ADC_W-1:0]    adc_in,
    output logic                busy,
    output logic                done_irq
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StPulse, StPre, StSense, StConv, StCapt, StDone
    } state_e;

    localparam logic [1:0] OpSet   = 2'd1;
    localparam logic [1:0] OpReset = 2'd2;
    localparam logic [1:0] OpMac   = 2'd3;
    localparam logic [7:0] PreLoad = 8'(PRE_CYC - 1);
    localparam logic [7:0] AdcLoad = 8'(ADC_CYC);
`ifdef RRAM_SEQ_VERIFY_EN
    localparam int unsigned CtrlW = 12 + ADC_W;
`else
    localparam int unsigned CtrlW = 8;
`endif

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADC_W-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic [1:0]         op_q;
    logic [CtrlW-1:0]   ctrl_q;
    logic [7:0]         pulse_cyc_q, sense_cyc_q, pulse_lat_q, sense_lat_q;
    logic               ack_q;
    logic [31:0]        dat_q, rdata;
`ifdef RRAM_SEQ_VERIFY_EN
    logic [1:0]         retry_q, retry_d;
    logic [ADC_W-1:0]   target_q;
`endif

    logic       acc, ctrl_wr, tim_wr, start_wr, start_go, write_op;
    logic [1:0] reg_sel;
    logic [7:0] pulse_load, sense_load;
    logic [ADC_W:0]   sum;
    logic [ADC_W-1:0] mac_val;
    logic             unused_bits;

    // ack_q gating guarantees the acknowledge never stays high two cycles in a row
    assign acc      = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    assign reg_sel  = wb.wbs_adr_i[3:2];
    assign ctrl_wr  = acc & wb.wbs_we_i & (reg_sel == 2'd0);
    assign tim_wr   = acc & wb.wbs_we_i & (reg_sel == 2'd1);
    assign start_wr = ctrl_wr & wb.wbs_dat_i[8];
    assign start_go = start_wr & (state_q == StIdle);
    assign write_op = (op_q == OpSet) || (op_q == OpReset);

    assign pulse_load = (pulse_lat_q == 8'd0) ? 8'd0 : pulse_lat_q - 8'd1;
    assign sense_load = (sense_lat_q == 8'd0) ? 8'd0 : sense_lat_q - 8'd1;

    assign sum     = {1'b0, result_q} + {1'b0, adc_in};
    assign mac_val = sum[ADC_W] ? '1 : sum[ADC_W-1:0];

    assign unused_bits   = ^{wb.wbs_dat_i[31:16], wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};
    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_dat_o  = dat_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef RRAM_SEQ_VERIFY_EN
        retry_d  = retry_q;
`endif
        if (ctrl_wr) begin
            if (!wb.wbs_dat_i[8]) begin
                err_d = 1'b0;
            end else if (state_q != StIdle) begin
                err_d = 1'b1;
            end
        end
        unique case (state_q)
            StIdle: begin
                if (start_wr) begin
                    state_d = StSetup;
`ifdef RRAM_SEQ_VERIFY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            StSetup: begin
                if (write_op) begin
                    state_d = StPulse;
                    cnt_d   = pulse_load;
                end else begin
                    state_d = StPre;
                    cnt_d   = PreLoad;
                end
            end
            StPulse: begin
                if (cnt_q == 8'd0) begin
`ifdef RRAM_SEQ_VERIFY_EN
                    state_d = StPre;
                    cnt_d   = PreLoad;
`else
                    state_d = StDone;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPre: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSense;
                    cnt_d   = sense_load;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSense: begin
                if (cnt_q == 8'd0) begin
                    state_d = StConv;
                    cnt_d   = AdcLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            // one sample cycle followed by ADC_CYC wait cycles
            StConv: begin
                if (cnt_q == 8'd0) begin
                    state_d = StCapt;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCapt: begin
                result_d = (op_q == OpMac) ? mac_val : adc_in;
                state_d  = StDone;
`ifdef RRAM_SEQ_VERIFY_EN
                if (write_op && (adc_in != target_q)) begin
                    if (retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        state_d = StPulse;
                        cnt_d   = pulse_load;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef RRAM_SEQ_VERIFY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef RRAM_SEQ_VERIFY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0: rdata[CtrlW-1:0] = ctrl_q;
            2'd1: rdata[15:0] = {sense_cyc_q, pulse_cyc_q};
            2'd2: begin
                rdata[0]         = busy;
                rdata[1]         = err_q;
                rdata[ADC_W+7:8] = result_q;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ctrl_q      <= '0;
            op_q        <= '0;
            wl_sel      <= '0;
            bl_sel      <= '0;
            sl_sel      <= '0;
            pulse_cyc_q <= 8'd8;
            sense_cyc_q <= 8'd4;
            pulse_lat_q <= 8'd8;
            sense_lat_q <= 8'd4;
`ifdef RRAM_SEQ_VERIFY_EN
            target_q    <= '0;
`endif
        end else begin
            ack_q <= acc;
            dat_q <= acc ? rdata : 32'd0;
            if (ctrl_wr) begin
`ifdef RRAM_SEQ_VERIFY_EN
                ctrl_q <= {wb.wbs_dat_i[CtrlW-1:9], 1'b0, wb.wbs_dat_i[7:0]};
`else
                ctrl_q <= wb.wbs_dat_i[7:0];
`endif
            end
            if (tim_wr) begin
                pulse_cyc_q <= wb.wbs_dat_i[7:0];
                sense_cyc_q <= wb.wbs_dat_i[15:8];
            end
            // operation fields and timing are frozen for the whole operation
            if (start_go) begin
                op_q        <= wb.wbs_dat_i[1:0];
                wl_sel      <= wb.wbs_dat_i[3:2];
                bl_sel      <= wb.wbs_dat_i[5:4];
                sl_sel      <= wb.wbs_dat_i[7:6];
                pulse_lat_q <= pulse_cyc_q;
                sense_lat_q <= sense_cyc_q;
`ifdef RRAM_SEQ_VERIFY_EN
                target_q    <= wb.wbs_dat_i[11+ADC_W:12];
`endif
            end
        end
    end

    // strobes decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_en    <= 1'b0;
            pre_en   <= 1'b0;
            csa_en   <= 1'b0;
            adc_smp  <= 1'b0;
            busy     <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            wl_en    <= (state_d == StPulse) || (state_d == StSense);
            pre_en   <= (state_d == StPre);
            csa_en   <= (state_d == StSense);
            adc_smp  <= (state_d == StConv) && (state_q != StConv);
            busy     <= (state_d != StIdle);
            done_irq <= (state_d == StDone);
        end
    end

endmodule

// File: doc/rram_op_sequencer.md
RRAM_OP_SEQUENCER -- requirements
Module: rram_op_sequencer

Interface
REQ-001 Parameter ADC_W, default 3: ADC result width.
REQ-002 Parameter PRE_CYC, default 4: precharge phase length in cycles, range 1..255.
REQ-003 Parameter ADC_CYC, default 8: ADC conversion wait in cycles, range 1..255.
REQ-004 clk  in  1  single clock, shared with the Wishbone bus.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
REQ-007 wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
REQ-008 wbs_dat_i  in  32  write data.
REQ-009 wbs_dat_o  out  32  read data.
REQ-010 wbs_ack_o  out  1  single-cycle acknowledge.
REQ-011 wl_sel, bl_sel, sl_sel  out  2 each  select among V1..V4 for WL, BL and SL.
REQ-012 wl_en, pre_en, csa_en, adc_smp  out  1 each  word-line drive, precharge, sense amplifier and ADC sample strobes.
REQ-013 adc_in  in  ADC_W  ADC code, valid in the cycle after adc_smp.
REQ-014 busy, done_irq  out  1 each  operation in flight; one-cycle completion pulse.

Function
REQ-015 Register map:
- 0x0 CTRL: bits [1:0] op (0 READ, 1 SET, 2 RESET, 3 MAC); bits [3:2] wl_v; [5:4] bl_v; [7:6] sl_v; bit 8 start (self-clearing).
- 0x4 TIMING: bits [7:0] pulse_cyc; bits [15:8] sense_cyc.
- 0x8 STATUS (read-only): bit 0 busy; bit 1 err; bits [ADC_W+7:8] last result.
REQ-016 wbs_ack_o SHALL assert for exactly one cycle, one cycle after cyc&stb is seen, and SHALL be low in the following cycle; unmapped addresses SHALL read 0 and ignore writes.
REQ-017 FSM states: IDLE, SETUP, PULSE, PRE, SENSE, CONV, CAPT, DONE.
REQ-018 IDLE->SETUP on a start write while idle; the CTRL fields are latched at that point and wl_sel/bl_sel/sl_sel SHALL drive those latched values for the whole operation.
REQ-019 SETUP lasts 1 cycle; then SET/RESET go to PULSE, READ/MAC go to PRE.
REQ-020 PULSE: wl_en=1 for pulse_cyc cycles, then DONE; pulse_cyc=0 SHALL be treated as 1.
REQ-021 PRE: pre_en=1 for PRE_CYC cycles. SENSE: wl_en=1 and csa_en=1 for sense_cyc cycles (0 treated as 1).
REQ-022 CONV: adc_smp=1 in the first cycle only, then wait ADC_CYC cycles. CAPT: register adc_in into result in 1 cycle.
REQ-023 DONE: done_irq=1 for 1 cycle, then IDLE.
REQ-024 MAC SHALL accumulate: result = saturating (result + adc_in), clamped at 2^ADC_W-1. READ SHALL overwrite result.
REQ-025 A start write while busy SHALL be acked, dropped, and set err. Any CTRL write with start=0 SHALL clear err.
REQ-026 TIMING writes while busy SHALL take effect on the next operation only; the active operation uses the counts latched at SETUP.
REQ-027 Outputs SHALL be registered; all strobes SHALL be 0 in IDLE and DONE.

Reset
REQ-028 On rst_n low, asynchronously: FSM=IDLE; all strobes, busy, done_irq, wbs_ack_o and err = 0; selects = 0; result = 0; pulse_cyc = 8; sense_cyc = 4.
REQ-029 Reset during any phase SHALL deassert wl_en/pre_en/csa_en immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro RRAM_SEQ_VERIFY_EN.
- Defined: after a SET/RESET PULSE, the FSM SHALL run PRE/SENSE/CONV/CAPT and compare the result against CTRL bits [11+ADC_W:12] (target). On mismatch it SHALL re-pulse, up to 3 retries; if the retries are exhausted it SHALL set err and go to DONE.
- Undefined: PULSE goes directly to DONE, and CTRL bits [31:9] are ignored.

Verification
REQ-031 READ, sense_cyc=2, adc_in=5 -> pre_en high 4 cycles, csa_en high 2 cycles, one adc_smp pulse, STATUS result=5, done_irq 1 cycle.
REQ-032 SET, pulse_cyc=3, wl_v=2 -> wl_sel=2 and wl_en high exactly 3 cycles, no csa_en, done_irq follows.
REQ-033 Three MAC ops with adc_in=6, ADC_W=3 -> result 6, then 7, then 7 (saturated).
REQ-034 Start written during SENSE -> acked, operation unaffected, err=1; CTRL write with start=0 -> err=0.
REQ-035 rst_n low mid-PULSE -> wl_en low immediately, busy=0, pulse_cyc reads 8.
REQ-036 With RRAM_SEQ_VERIFY_EN, target=4, adc_in stuck at 1 -> 4 pulses total, err=1, done_irq once.
